// File: rtl/eh2_ram_banked.sv
// Banked single-port synchronous SRAM model with a valid/ready request port,
// per-slice write mask, 1- or 2-cycle read latency and optional zero-fill after reset.

module eh2_ram_bank #(
  parameter int ROWS    = 1024,
  parameter int WIDTH   = 39,
  parameter int BE_GRAN = 39,
  parameter int RW      = 10
) (
  input  logic                     clk,
  input  logic                     me,
  input  logic                     we,
  input  logic [RW-1:0]            addr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [WIDTH/BE_GRAN-1:0] wmask,
  output logic [WIDTH-1:0]         dout
);
  localparam int MW = WIDTH / BE_GRAN;

  logic [WIDTH-1:0] mem [ROWS];
  logic [WIDTH-1:0] merged;

  // Merge is built combinationally so the array sees one whole-row write.
  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < MW; i++)
      if (wmask[i]) merged[i*BE_GRAN +: BE_GRAN] = wdata[i*BE_GRAN +: BE_GRAN];
  end

  always_ff @(posedge clk) begin
    if (me && we)  mem[addr] <= merged;
    if (me && !we) dout      <= mem[addr];
  end
endmodule

module eh2_ram_banked #(
  parameter int DEPTH   = 4096,
  parameter int WIDTH   = 39,
  parameter int BANKS   = 4,
  parameter int BE_GRAN = WIDTH,
  parameter int RD_LAT  = 1,
  parameter int INIT_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wr,
  input  logic [$clog2(DEPTH)-1:0]   req_addr,
  input  logic [WIDTH-1:0]           req_wdata,
  input  logic [WIDTH/BE_GRAN-1:0]   req_wmask,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       init_done,
  output logic [BANKS-1:0]           bank_me
);
  localparam int AW   = $clog2(DEPTH);
  localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int ROWS = DEPTH / BANKS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MW   = WIDTH / BE_GRAN;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INIT = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]             state;
  logic [RW-1:0]          cnt;
  logic [BW-1:0]          bank_sel;
  logic [RW-1:0]          row;
  logic                   acc, rd_acc, in_init;
  logic [RW-1:0]          b_addr;
  logic [WIDTH-1:0]       b_wdata;
  logic [MW-1:0]          b_wmask;
  logic                   b_we;
  logic [BANKS-1:0][WIDTH-1:0] bank_dout;
  logic [WIDTH-1:0]       arr_rd;
  logic [RD_LAT:1]        vld_pipe;

  generate
    if (BANKS == 1) begin : g_sel1
      assign bank_sel = '0;
    end else begin : g_seln
      assign bank_sel = req_addr[BW-1:0];
    end
    if (ROWS == 1) begin : g_row1
      assign row = '0;
    end else if (BANKS == 1) begin : g_rowa
      assign row = req_addr;
    end else begin : g_rown
      assign row = req_addr[AW-1:BW];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          state <= (INIT_EN != 0) ? INIT : RUN;
        end
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == RW'(ROWS - 1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign in_init   = (state == INIT);
  assign req_ready = (state == RUN);
  assign init_done = (state == RUN);
  assign acc       = req_valid && req_ready;
  assign rd_acc    = acc && !req_wr;

  // During zero-fill every bank writes row cnt in parallel.
  assign b_we    = in_init || req_wr;
  assign b_addr  = in_init ? cnt : row;
  assign b_wdata = in_init ? '0 : req_wdata;
  assign b_wmask = in_init ? '1 : req_wmask;

  genvar b;
  generate
    for (b = 0; b < BANKS; b++) begin : g_bank
      assign bank_me[b] = in_init || (acc && (bank_sel == BW'(b)));
      eh2_ram_bank #(.ROWS(ROWS), .WIDTH(WIDTH), .BE_GRAN(BE_GRAN), .RW(RW)) u_bank (
        .clk   (clk),
        .me    (bank_me[b]),
        .we    (b_we),
        .addr  (b_addr),
        .wdata (b_wdata),
        .wmask (b_wmask),
        .dout  (bank_dout[b])
      );
    end

    if (BANKS == 1) begin : g_mux1
      assign arr_rd = bank_dout[0];
    end else begin : g_muxn
      logic [BW-1:0] rd_bank;
      always_ff @(posedge clk)
        if (rd_acc) rd_bank <= bank_sel;
      assign arr_rd = bank_dout[rd_bank];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= rd_acc;
      for (int s = 2; s <= RD_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end
  assign rd_valid = vld_pipe[RD_LAT];

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign rd_data = arr_rd;
    end else begin : g_lat2
      // Output stage after the array; holds until the next read lands.
      logic [WIDTH-1:0] rd_q;
      always_ff @(posedge clk)
        if (vld_pipe[1]) rd_q <= arr_rd;
      assign rd_data = rd_q;
    end
  endgenerate
endmodule
